// File: rtl/ninjin_s_axi_image_pkg.sv
// rtl/ninjin_s_axi_image_pkg.sv - shared widths, word mapping helper and AXI response codes
package ninjin_s_axi_image_pkg;

  localparam int BWIDTH   = 32;
  localparam int WORDSIZE = 10;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int LSB = clogb2(BWIDTH / 8 - 1);

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;

endpackage

// File: rtl/ninjin_skid_fifo.sv
// rtl/ninjin_skid_fifo.sv - two-entry valid/ready FIFO decoupling RAM read latency from R backpressure
module ninjin_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic [WIDTH-1:0] s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] slot_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             push;
  logic             pop;

  assign s_tready_o = (count_q != 2'd2);
  assign m_tvalid_o = (count_q != 2'd0);
  assign m_tdata_o  = slot_q[rd_ptr_q];
  assign count_o    = count_q;

  assign push    = s_tvalid_i & s_tready_o;
  assign pop     = m_tvalid_o & m_tready_i;
  assign count_d = count_q + 2'(push) - 2'(pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push) begin
        slot_q[wr_ptr_q] <= s_tdata_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ninjin_s_axi_image.sv
// rtl/ninjin_s_axi_image.sv - AXI4 INCR burst slave fronting the dual-port image RAM
module ninjin_s_axi_image
  import ninjin_s_axi_image_pkg::*;
#(
  parameter int DATA_WIDTH = BWIDTH,
  parameter int ADDR_WIDTH = BWIDTH
) (
  input  logic                  clk,
  input  logic                  xrst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wlast,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  output logic                  mem_we,
  output logic [WORDSIZE-1:0]   mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [WORDSIZE-1:0]   mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SHIFT = clogb2(DATA_WIDTH / 8 - 1);
  localparam int EW    = ADDR_WIDTH + 1;
  localparam logic [EW-1:0] LIMIT = EW'(1) << WORDSIZE;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic burst_oor(input logic [ADDR_WIDTH-1:0] addr, input logic [7:0] len_m1);
    logic [EW-1:0] end_excl;
    end_excl = EW'(addr >> SHIFT) + EW'(len_m1) + EW'(1);
    return end_excl > LIMIT;
  endfunction

  function automatic logic [WORDSIZE-1:0] word_of(input logic [ADDR_WIDTH-1:0] addr);
    return WORDSIZE'(addr >> SHIFT);
  endfunction

  w_state_e                w_state_q, w_state_d;
  logic [WORDSIZE-1:0]     w_base_q, w_base_d;
  logic [7:0]              w_len_q, w_len_d;
  logic [7:0]              w_idx_q, w_idx_d;
  logic                    w_oor_q, w_oor_d;
  logic                    w_err_q, w_err_d;
  logic                    mem_we_q, mem_we_d;
  logic [WORDSIZE-1:0]     mem_waddr_q, mem_waddr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  assign awready   = (w_state_q == W_IDLE) & ~xrst;
  assign wready    = (w_state_q == W_DATA);
  assign bvalid    = (w_state_q == W_RESP);
  assign bresp     = (bvalid && (w_oor_q || w_err_q)) ? AXI_SLVERR : AXI_OKAY;
  assign mem_we    = mem_we_q;
  assign mem_waddr = mem_waddr_q;
  assign mem_wdata = mem_wdata_q;

  always_comb begin
    w_state_d   = w_state_q;
    w_base_d    = w_base_q;
    w_len_d     = w_len_q;
    w_idx_d     = w_idx_q;
    w_oor_d     = w_oor_q;
    w_err_d     = w_err_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_base_d  = word_of(awaddr);
          w_len_d   = awlen;
          w_idx_d   = 8'd0;
          w_oor_d   = burst_oor(awaddr, awlen);
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          mem_we_d    = ~w_oor_q;
          mem_waddr_d = w_base_q + WORDSIZE'(w_idx_q);
          mem_wdata_d = wdata;
          // The beat count from awlen ends the burst; wlast only grades it.
          if (wlast != (w_idx_q == w_len_q)) begin
            w_err_d = 1'b1;
          end
          if (w_idx_q == w_len_q) begin
            w_state_d = W_RESP;
          end else begin
            w_idx_d = w_idx_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      w_state_q   <= W_IDLE;
      w_base_q    <= '0;
      w_len_q     <= '0;
      w_idx_q     <= '0;
      w_oor_q     <= 1'b0;
      w_err_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      w_state_q   <= w_state_d;
      w_base_q    <= w_base_d;
      w_len_q     <= w_len_d;
      w_idx_q     <= w_idx_d;
      w_oor_q     <= w_oor_d;
      w_err_q     <= w_err_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  r_state_e                r_state_q, r_state_d;
  logic [WORDSIZE-1:0]     r_base_q, r_base_d;
  logic [7:0]              r_len_q, r_len_d;
  logic                    r_oor_q, r_oor_d;
  logic [8:0]              r_iss_q, r_iss_d;
  logic [7:0]              r_out_q, r_out_d;
  logic                    r_infl_q, r_infl_d;
  logic [1:0]              f_count;
  logic                    f_in_ready;
  logic                    pop;
  logic [2:0]              occ;
  logic                    issue_ok;

  assign arready = (r_state_q == R_IDLE) & ~xrst;
  assign pop     = rvalid & rready;
  assign occ     = 3'(f_count) + 3'(r_infl_q);
  // Credit the slot freed by this cycle's pop so rready=1 sustains one beat per cycle.
  assign issue_ok = occ < (3'd2 + 3'(pop));
  assign rlast    = rvalid && (r_out_q == r_len_q);
  assign rresp    = (rvalid && r_oor_q) ? AXI_SLVERR : AXI_OKAY;

  always_comb begin
    r_state_d = r_state_q;
    r_base_d  = r_base_q;
    r_len_d   = r_len_q;
    r_oor_d   = r_oor_q;
    r_iss_d   = r_iss_q;
    r_out_d   = r_out_q;
    r_infl_d  = 1'b0;
    mem_raddr = r_base_q + WORDSIZE'(r_iss_q);
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          // First beat is fetched in the handshake cycle itself.
          r_base_d  = word_of(araddr);
          r_len_d   = arlen;
          r_oor_d   = burst_oor(araddr, arlen);
          r_iss_d   = 9'd1;
          r_out_d   = 8'd0;
          r_infl_d  = 1'b1;
          mem_raddr = word_of(araddr);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if ((r_iss_q <= {1'b0, r_len_q}) && issue_ok) begin
          r_infl_d = 1'b1;
          r_iss_d  = r_iss_q + 9'd1;
        end
        if (pop) begin
          if (r_out_q == r_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_out_d = r_out_q + 8'd1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge xrst) begin
    if (xrst) begin
      r_state_q <= R_IDLE;
      r_base_q  <= '0;
      r_len_q   <= '0;
      r_oor_q   <= 1'b0;
      r_iss_q   <= '0;
      r_out_q   <= '0;
      r_infl_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_base_q  <= r_base_d;
      r_len_q   <= r_len_d;
      r_oor_q   <= r_oor_d;
      r_iss_q   <= r_iss_d;
      r_out_q   <= r_out_d;
      r_infl_q  <= r_infl_d;
    end
  end

  ninjin_skid_fifo #(
    .WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk_i      (clk),
    .rst_i      (xrst),
    .s_tvalid_i (r_infl_q & f_in_ready),
    .s_tready_o (f_in_ready),
    .s_tdata_i  (mem_rdata),
    .m_tvalid_o (rvalid),
    .m_tready_i (rready),
    .m_tdata_o  (rdata),
    .count_o    (f_count)
  );

endmodule

// File: tb/tb_ninjin_s_axi_image.sv
// tb/tb_ninjin_s_axi_image.sv - vector table, hand sequences and random bursts against a shadow-memory model
module tb_ninjin_s_axi_image;
  import ninjin_s_axi_image_pkg::*;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int NWORDS = 1 << WORDSIZE;

  logic              clk;
  logic              xrst;
  logic              awvalid, awready;
  logic [AW-1:0]     awaddr;
  logic [7:0]        awlen;
  logic              wvalid, wready, wlast;
  logic [DW-1:0]     wdata;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic              arvalid, arready;
  logic [AW-1:0]     araddr;
  logic [7:0]        arlen;
  logic              rvalid, rready, rlast;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              mem_we;
  logic [WORDSIZE-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0]     mem_wdata, mem_rdata;

  ninjin_s_axi_image #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .xrst(xrst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] ram [NWORDS];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  typedef struct { int addr; logic [DW-1:0] data; } wr_t;
  wr_t got_w[$];
  always @(negedge clk) begin
    if (!xrst && mem_we) got_w.push_back('{int'(mem_waddr), mem_wdata});
  end

  logic [DW-1:0] model_mem [int];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_oor(input logic [AW-1:0] addr, input int len_m1);
    return (int'(addr >> LSB) + len_m1 + 1) > NWORDS;
  endfunction

  task automatic do_write(input logic [AW-1:0] addr, input int len_m1, input int wlast_at,
                          input bit gaps, input bit seq, output logic [1:0] resp);
    logic [DW-1:0] data[$];
    int t;
    int word;
    word = int'(addr >> LSB);
    got_w.delete();
    awaddr = addr; awlen = 8'(len_m1); awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin cyc(); t++; end
    if (!awready) check("aw_timeout", 64'(awready), 64'd1);
    cyc();
    awvalid = 1'b0;
    for (int i = 0; i <= len_m1; i++) begin
      if (gaps) while ($urandom_range(3) == 0) cyc();
      wdata  = seq ? DW'(i + 1) : $urandom;
      wlast  = (i == wlast_at);
      wvalid = 1'b1;
      data.push_back(wdata);
      t = 0;
      while (!wready && t < 50) begin cyc(); t++; end
      if (!wready) check("w_timeout", 64'(wready), 64'd1);
      cyc();
      wvalid = 1'b0; wlast = 1'b0;
    end
    if (gaps) repeat ($urandom_range(2)) cyc();
    t = 0;
    while (!bvalid && t < 50) begin cyc(); t++; end
    if (!bvalid) check("b_timeout", 64'(bvalid), 64'd1);
    resp = bresp;
    bready = 1'b1;
    cyc();
    bready = 1'b0;
    cyc();
    if (model_oor(addr, len_m1)) begin
      check("wr_count_oor", 64'(got_w.size()), 64'd0);
    end else begin
      check("wr_count", 64'(got_w.size()), 64'(len_m1 + 1));
      for (int i = 0; i <= len_m1; i++) begin
        if (i < got_w.size()) begin
          check("wr_addr", 64'(got_w[i].addr), 64'(word + i));
          check("wr_data", 64'(got_w[i].data), 64'(data[i]));
        end
        model_mem[word + i] = data[i];
      end
    end
  endtask

  // mode 0: rready held high, 1: random rready, 2: rready pattern 1,0,0,1
  task automatic do_read(input logic [AW-1:0] addr, input int len_m1, input int mode,
                         input logic [1:0] exp_resp);
    int t, beats, first_t, last_t, word;
    bit oor, prev_stall;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    word = int'(addr >> LSB);
    oor = model_oor(addr, len_m1);
    araddr = addr; arlen = 8'(len_m1); arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin cyc(); t++; end
    if (!arready) check("ar_timeout", 64'(arready), 64'd1);
    cyc();
    arvalid = 1'b0;
    beats = 0; t = 0; first_t = -1; last_t = -1; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0;
    while (beats <= len_m1 && t < 400) begin
      case (mode)
        0:       rready = 1'b1;
        1:       rready = 1'($urandom_range(1));
        default: rready = pat[t % 4];
      endcase
      if (prev_stall) begin
        check("r_hold_valid", 64'(rvalid), 64'd1);
        check("r_hold_data", 64'(rdata), 64'(prev_data));
        check("r_hold_last", 64'(rlast), 64'(prev_last));
      end
      if (rvalid && rready) begin
        if (first_t < 0) first_t = t;
        last_t = t;
        if (!oor) check("rdata", 64'(rdata), 64'(model_mem[word + beats]));
        check("rresp", 64'(rresp), 64'(exp_resp));
        check("rlast", 64'(rlast), 64'(beats == len_m1));
        beats++;
      end
      prev_stall = rvalid && !rready;
      prev_data  = rdata;
      prev_last  = rlast;
      cyc();
      t++;
    end
    rready = 1'b0;
    check("r_beats", 64'(beats), 64'(len_m1 + 1));
    check("r_idle_valid", 64'(rvalid), 64'd0);
    check("r_idle_arready", 64'(arready), 64'd1);
    if (mode == 0) begin
      check("r_first_latency", 64'(first_t), 64'd1);
      check("r_back_to_back", 64'(last_t - first_t), 64'(len_m1));
    end
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    int            len_m1;
    int            wlast_at;
    bit            seq;
    int            mode;
    logic [1:0]    exp_bresp;
    logic [1:0]    exp_rresp;
  } vec_t;

  vec_t vecs[$];
  logic [1:0] resp;

  initial begin
    vecs.push_back('{32'h40, 3, 3, 1'b1, 0, AXI_OKAY, AXI_OKAY});
    vecs.push_back('{32'h40, 3, 3, 1'b1, 2, AXI_OKAY, AXI_OKAY});
    vecs.push_back('{32'((NWORDS - 2) << LSB), 3, 3, 1'b0, 0, AXI_SLVERR, AXI_SLVERR});
    vecs.push_back('{32'h100, 3, 2, 1'b0, 1, AXI_SLVERR, AXI_OKAY});
    vecs.push_back('{32'h8, 0, 0, 1'b0, 0, AXI_OKAY, AXI_OKAY});
    vecs.push_back('{32'((NWORDS - 4) << LSB), 3, 3, 1'b0, 1, AXI_OKAY, AXI_OKAY});
    vecs.push_back('{32'((NWORDS - 1) << LSB), 0, 0, 1'b0, 0, AXI_OKAY, AXI_OKAY});
    vecs.push_back('{32'h200, 1, -1, 1'b0, 2, AXI_SLVERR, AXI_OKAY});

    for (int i = 0; i < NWORDS; i++) ram[i] = '0;
    xrst = 1'b1;
    awvalid = 0; awaddr = '0; awlen = '0; wvalid = 0; wdata = '0; wlast = 0; bready = 0;
    arvalid = 0; araddr = '0; arlen = '0; rready = 0;
    cyc(); cyc();
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_raddr", 64'(mem_raddr), 64'd0);
    xrst = 1'b0;
    cyc();
    check("post_rst_awready", 64'(awready), 64'd1);
    check("post_rst_arready", 64'(arready), 64'd1);

    foreach (vecs[i]) begin
      do_write(vecs[i].addr, vecs[i].len_m1, vecs[i].wlast_at, 1'b0, vecs[i].seq, resp);
      check($sformatf("vec%0d_bresp", i), 64'(resp), 64'(vecs[i].exp_bresp));
      do_read(vecs[i].addr, vecs[i].len_m1, vecs[i].mode, vecs[i].exp_rresp);
    end

    // Reset in the middle of a read burst drops it without a response.
    do_write(32'h40, 3, 3, 1'b0, 1'b1, resp);
    araddr = 32'h40; arlen = 8'd7; arvalid = 1'b1;
    cyc();
    arvalid = 1'b0;
    cyc(); cyc();
    check("midrd_rvalid", 64'(rvalid), 64'd1);
    xrst = 1'b1;
    #1;
    check("midrd_rst_rvalid", 64'(rvalid), 64'd0);
    check("midrd_rst_arready", 64'(arready), 64'd0);
    cyc();
    xrst = 1'b0;
    cyc();
    check("midrd_post_rvalid", 64'(rvalid), 64'd0);
    check("midrd_post_arready", 64'(arready), 64'd1);
    do_read(32'h40, 3, 0, AXI_OKAY);

    for (int n = 0; n < 20; n++) begin
      int word, len, wl;
      logic [AW-1:0] addr;
      logic [1:0] exp_b;
      word = ($urandom_range(3) == 0) ? NWORDS - 1 - int'($urandom_range(15))
                                      : int'($urandom_range(NWORDS - 1));
      len  = int'($urandom_range(15));
      wl   = ($urandom_range(4) == 0) ? int'($urandom_range(len + 1)) - 1 : len;
      addr = AW'(word) << LSB;
      exp_b = (model_oor(addr, len) || wl != len) ? AXI_SLVERR : AXI_OKAY;
      do_write(addr, len, wl, 1'b1, 1'b0, resp);
      check("rand_bresp", 64'(resp), 64'(exp_b));
      do_read(addr, len, 1, model_oor(addr, len) ? AXI_SLVERR : AXI_OKAY);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
